ram_banked: RTL and testbench
=============================

RAM_BANKED -- requirements
Module: ram_banked

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width; DEPTH = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, data width; a multiple of 8; NB = DATA_W/8 byte lanes.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1: 1 = zero every word after reset, 0 = skip the clear.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port mem_en  input  1  request valid.
REQ-007 SHALL have port mem_write  input  1  1 = write, 0 = read; sampled with mem_en.
REQ-008 SHALL have port addr  input  ADDR_W  word address.
REQ-009 SHALL have port data_in  input  DATA_W  write data.
REQ-010 SHALL have port wstrb  input  NB  byte-lane write enables; bit i covers data_in[8i+7:8i].
REQ-011 SHALL have port ready  output  1  request accepted this cycle when mem_en && ready.
REQ-012 SHALL have port data_out  output  DATA_W  read data, valid while ack is high for a read.
REQ-013 SHALL have port ack  output  1  one-cycle pulse per accepted request.

Function
REQ-014 SHALL have states CLEAR and IDLE; reset enters CLEAR if CLEAR_ON_RESET=1, else IDLE.
REQ-015 In CLEAR, SHALL write zero to one word per cycle using a clear counter 0..DEPTH-1, hold ready=0, and move to IDLE the cycle after word DEPTH-1 is written.
REQ-016 In IDLE, ready SHALL be 1 every cycle; requests are fully pipelined, one per cycle, with no bubbles.
REQ-017 SHALL ignore mem_en while ready=0: no memory change, no ack.
REQ-018 An accepted write SHALL update only the byte lanes whose wstrb bit is set; wstrb=0 SHALL still produce ack and leave memory unchanged.
REQ-019 SHALL return ack for an accepted request LAT cycles after acceptance (LAT per REQ-027/028), in request order.
REQ-020 On an accepted read, data_out SHALL equal the word at addr, including the effect of any write accepted in an earlier cycle (read-after-write on consecutive cycles returns new data).
REQ-021 SHALL hold data_out at its last read value while ack is low or the acked request is a write.
REQ-022 SHALL use only addr[ADDR_W-1:0]; there is no out-of-range case.

Reset
REQ-023 While rst=1: ack=0, ready=0, data_out=0, pipeline valid bits cleared, clear counter=0.
REQ-024 Requests in flight when rst is asserted SHALL be dropped without ack; memory writes already committed persist unless CLEAR rewrites them.
REQ-025 Reset asserted during CLEAR SHALL restart the clear from word 0.
REQ-026 Memory contents are not reset except by the CLEAR sweep.

Configuration
REQ-027 Macro RAM_BANKED_OUTREG_EN defined: an extra output register follows the array read; LAT=2; data_out and ack both delayed one more cycle.
REQ-028 Macro undefined: LAT=1; data_out driven straight from the array read register.

Structure
REQ-029 Package ram_banked_pkg SHALL hold the state enum (CLEAR, IDLE) and the LAT constant derived from RAM_BANKED_OUTREG_EN.
REQ-030 Sub-module ram_banked_array SHALL hold the storage: one synchronous read port and one byte-masked write port; the top owns the FSM, the clear mux and the ack pipeline.

Verification
REQ-031 Reset with CLEAR_ON_RESET=1, ADDR_W=4 -> ready=0 for exactly 16 cycles, then 1; a read of every address returns 0.
REQ-032 Write 0xDEADBEEF at addr 3, wstrb=4'b1111; then write 0x11223344 at addr 3, wstrb=4'b0101; read addr 3 -> 0xDE22BE44, with ack exactly LAT cycles after each request.
REQ-033 Back-to-back: write addr 5 = 0xA5A5A5A5 in cycle N, read addr 5 in cycle N+1 -> read data 0xA5A5A5A5; ack high on cycles N+LAT and N+1+LAT.
REQ-034 mem_en held 1 during CLEAR -> no ack and no memory change; after IDLE the cleared contents are intact.
REQ-035 Read issued, then rst pulsed on the next cycle -> no ack appears; data_out=0; the CLEAR sweep restarts.
REQ-036 Run the suite with RAM_BANKED_OUTREG_EN both defined and undefined -> ack latency 2 and 1 cycles respectively.

Source files
------------

// File: rtl/ram_banked_pkg.sv
// Shared types and latency constant for the banked RAM.
// The RAM_BANKED_OUTREG_EN macro selects the optional output register (LAT=2).
package ram_banked_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

`ifdef RAM_BANKED_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

endpackage

// File: rtl/ram_banked_array.sv
// Word storage with one byte-masked write port and one registered read port.
// Contents are never reset; only the read register is.
module ram_banked_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   wmask,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_W-1:0]     rdata
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (we && wmask[i]) begin
                mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    // p1: array read register; reads see every write committed on an earlier edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_banked.sv
// Single-port byte-masked RAM with optional zeroing sweep after reset.
// Define RAM_BANKED_OUTREG_EN to add an output register (ack/data one cycle later).
module ram_banked
    import ram_banked_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_en,
    input  logic                  mem_write,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     data_in,
    input  logic [DATA_W/8-1:0]   wstrb,
    output logic                  ready,
    output logic [DATA_W-1:0]     data_out,
    output logic                  ack
);

    localparam int NB = DATA_W / 8;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   clr_cnt;
    logic [ADDR_W-1:0]   clr_cnt_nxt;

    logic                accept_p0;
    logic                arr_we;
    logic                arr_re;
    logic [ADDR_W-1:0]   arr_waddr;
    logic [DATA_W-1:0]   arr_wdata;
    logic [NB-1:0]       arr_wmask;

    logic                vld_p1;
    logic [DATA_W-1:0]   rdata_p1;

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        ready       = 1'b0;
        arr_we      = 1'b0;
        arr_waddr   = addr;
        arr_wdata   = data_in;
        arr_wmask   = wstrb;

        case (state)
            CLEAR: begin
                arr_we    = 1'b1;
                arr_waddr = clr_cnt;
                arr_wdata = '0;
                arr_wmask = '1;
                if (&clr_cnt) begin
                    state_nxt   = IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            IDLE: begin
                ready = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Reset masks everything combinationally so nothing leaks in the reset cycle
        if (rst) begin
            ready  = 1'b0;
            arr_we = 1'b0;
        end

        accept_p0 = mem_en & ready;
        arr_re    = accept_p0 & ~mem_write;
        if (state == IDLE) begin
            arr_we = accept_p0 & mem_write;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    ram_banked_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .waddr (arr_waddr),
        .wdata (arr_wdata),
        .wmask (arr_wmask),
        .re    (arr_re),
        .raddr (addr),
        .rdata (rdata_p1)
    );

    // p1: request valid aligned with the array read register
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= accept_p0;
        end
    end

`ifdef RAM_BANKED_OUTREG_EN
    logic                rd_p1;
    logic                vld_p2;
    logic [DATA_W-1:0]   dout_p2;

    // p2: output register; only reads refresh the held data
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_p1   <= 1'b0;
            vld_p2  <= 1'b0;
            dout_p2 <= '0;
        end else begin
            rd_p1  <= arr_re;
            vld_p2 <= vld_p1;
            if (rd_p1) begin
                dout_p2 <= rdata_p1;
            end
        end
    end

    assign ack      = vld_p2 & ~rst;
    assign data_out = rst ? '0 : dout_p2;
`else
    assign ack      = vld_p1 & ~rst;
    assign data_out = rst ? '0 : rdata_p1;
`endif

endmodule

// File: tb/tb_ram_banked.sv
// Scoreboard bench for ram_banked (ADDR_W=4, DATA_W=32, CLEAR_ON_RESET=1).
// Expected latency follows LAT from ram_banked_pkg for either macro setting.
module tb_ram_banked;
    import ram_banked_pkg::*;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NB    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_en;
    logic          mem_write;
    logic [AW-1:0] addr;
    logic [DW-1:0] data_in;
    logic [NB-1:0] wstrb;
    logic          ready;
    logic [DW-1:0] data_out;
    logic          ack;

    typedef struct {
        int            due;
        bit            rd;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        bit            en;
        bit            wr;
        int            a;
        logic [DW-1:0] d;
        logic [NB-1:0] s;
    } req_t;

    exp_t          sb[$];
    req_t          plan[$];
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_rd;
    int            cyc = 0;
    int            n_chk = 0;
    int            n_fail = 0;

    ram_banked #(
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .CLEAR_ON_RESET (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_en    (mem_en),
        .mem_write (mem_write),
        .addr      (addr),
        .data_in   (data_in),
        .wstrb     (wstrb),
        .ready     (ready),
        .data_out  (data_out),
        .ack       (ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, required finish before 2ms");
        $fatal(1, "timeout");
    end

    task automatic idle();
        mem_en    = 1'b0;
        mem_write = 1'b0;
        addr      = '0;
        data_in   = '0;
        wstrb     = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        sb.delete();
        last_rd = '0;
    endtask

    task automatic add_req(input bit en, input bit wr, input int a,
                           input logic [DW-1:0] d, input logic [NB-1:0] s);
        req_t r;
        r.en = en; r.wr = wr; r.a = a; r.d = d; r.s = s;
        plan.push_back(r);
    endtask

    // Drive one accepted request and record what the DUT must return for it.
    task automatic issue(input req_t r);
        exp_t e;
        mem_en    = 1'b1;
        mem_write = r.wr;
        addr      = AW'(r.a);
        data_in   = r.d;
        wstrb     = r.s;
        if (r.wr) begin
            for (int i = 0; i < NB; i++)
                if (r.s[i]) model[r.a][8*i +: 8] = r.d[8*i +: 8];
        end
        e.due  = cyc + LAT;
        e.rd   = !r.wr;
        e.data = model[r.a];
        sb.push_back(e);
    endtask

    task automatic test_reset();
        int cnt;
        exp_t e;
        @(posedge clk); #1;
        idle();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            n_chk += 3;
            if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b required 0", ready); end
            if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b required 0", ack); end
            if (data_out !== '0) begin n_fail++; $display("FAIL reset_data got %h required 0", data_out); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
            cnt++;
        end
        n_chk++;
        if (cnt != DEPTH) begin n_fail++; $display("FAIL reset_clear_len got %0d cycles, required %0d", cnt, DEPTH); end

        plan.delete();
        for (int a = 0; a < DEPTH; a++) add_req(1, 0, a, '0, '0);
        for (int i = 0; i < plan.size() + LAT + 2; i++) begin
            @(posedge clk); #1;
            if (i < plan.size() && plan[i].en) issue(plan[i]); else idle();
            @(negedge clk);
            n_chk++;
            if (ack) begin
                if (sb.size() == 0) begin n_fail++; $display("FAIL reset_spurious_ack at cyc %0d, required none", cyc); end
                else begin
                    e = sb.pop_front();
                    if (cyc != e.due) begin n_fail++; $display("FAIL reset_ack_cycle got %0d required %0d", cyc, e.due); end
                    if (e.rd) last_rd = e.data;
                    n_chk++;
                    if (data_out !== last_rd) begin n_fail++; $display("FAIL reset_read_data got %h required %h", data_out, last_rd); end
                end
            end else if (data_out !== last_rd) begin n_fail++; $display("FAIL reset_hold got %h required %h", data_out, last_rd); end
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL reset_missing_ack got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_strobe();
        exp_t e;
        plan.delete();
        add_req(1, 1, 3, 32'hDEADBEEF, 4'b1111);
        add_req(1, 1, 3, 32'h11223344, 4'b0101);
        add_req(1, 0, 3, '0, '0);
        add_req(1, 1, 4, 32'hCAFEF00D, 4'b1111);
        add_req(1, 1, 4, 32'hFFFFFFFF, 4'b0000);
        add_req(1, 0, 4, '0, '0);
        add_req(0, 0, 0, '0, '0);
        add_req(1, 1, 3, 32'h99000000, 4'b1000);
        add_req(1, 0, 3, '0, '0);
        for (int i = 0; i < plan.size() + LAT + 2; i++) begin
            @(posedge clk); #1;
            if (i < plan.size() && plan[i].en) issue(plan[i]); else idle();
            @(negedge clk);
            n_chk++;
            if (ack) begin
                if (sb.size() == 0) begin n_fail++; $display("FAIL strobe_spurious_ack at cyc %0d, required none", cyc); end
                else begin
                    e = sb.pop_front();
                    if (cyc != e.due) begin n_fail++; $display("FAIL strobe_ack_cycle got %0d required %0d", cyc, e.due); end
                    if (e.rd) last_rd = e.data;
                    n_chk++;
                    if (data_out !== last_rd) begin n_fail++; $display("FAIL strobe_data got %h required %h", data_out, last_rd); end
                end
            end else if (data_out !== last_rd) begin n_fail++; $display("FAIL strobe_hold got %h required %h", data_out, last_rd); end
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL strobe_missing_ack got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        plan.delete();
        add_req(1, 1, 5, 32'hA5A5A5A5, 4'b1111);
        add_req(1, 0, 5, '0, '0);
        for (int k = 0; k < 48; k++)
            add_req(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    $urandom_range(0, DEPTH - 1), $urandom(), 4'($urandom_range(0, 15)));
        for (int i = 0; i < plan.size() + LAT + 2; i++) begin
            @(posedge clk); #1;
            if (i < plan.size() && plan[i].en) issue(plan[i]); else idle();
            @(negedge clk);
            n_chk++;
            if (ack) begin
                if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_spurious_ack at cyc %0d, required none", cyc); end
                else begin
                    e = sb.pop_front();
                    if (cyc != e.due) begin n_fail++; $display("FAIL b2b_ack_cycle got %0d required %0d", cyc, e.due); end
                    if (e.rd) last_rd = e.data;
                    n_chk++;
                    if (data_out !== last_rd) begin n_fail++; $display("FAIL b2b_data got %h required %h", data_out, last_rd); end
                end
            end else if (data_out !== last_rd) begin n_fail++; $display("FAIL b2b_hold got %h required %h", data_out, last_rd); end
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL b2b_missing_ack got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_clear_ignore();
        exp_t e;
        int   k;
        bit   seen;
        @(posedge clk); #1;
        rst       = 1'b1;
        mem_en    = 1'b1;
        mem_write = 1'b1;
        data_in   = 32'hFFFFFFFF;
        wstrb     = 4'b1111;
        addr      = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        seen = 1'b0;
        for (k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ready === 1'b1) begin seen = 1'b1; break; end
            n_chk++;
            if (ack !== 1'b0) begin n_fail++; $display("FAIL clear_ack got %b required 0", ack); end
            @(posedge clk); #1;
            addr = AW'(k + 8);
        end
        idle();
        n_chk++;
        if (!seen) begin n_fail++; $display("FAIL clear_ready got 0 after %0d cycles, required 1", k); end

        plan.delete();
        for (int a = 0; a < DEPTH; a++) add_req(1, 0, a, '0, '0);
        for (int i = 0; i < plan.size() + LAT + 2; i++) begin
            @(posedge clk); #1;
            if (i < plan.size() && plan[i].en) issue(plan[i]); else idle();
            @(negedge clk);
            n_chk++;
            if (ack) begin
                if (sb.size() == 0) begin n_fail++; $display("FAIL clear_spurious_ack at cyc %0d, required none", cyc); end
                else begin
                    e = sb.pop_front();
                    if (cyc != e.due) begin n_fail++; $display("FAIL clear_ack_cycle got %0d required %0d", cyc, e.due); end
                    if (e.rd) last_rd = e.data;
                    n_chk++;
                    if (data_out !== last_rd) begin n_fail++; $display("FAIL clear_contents got %h required %h", data_out, last_rd); end
                end
            end else if (data_out !== last_rd) begin n_fail++; $display("FAIL clear_hold got %h required %h", data_out, last_rd); end
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL clear_missing_ack got %0d pending, required 0", sb.size()); end
    endtask

    task automatic test_reset_inflight();
        exp_t e;
        int   cnt;
        plan.delete();
        add_req(1, 1, 9, 32'h12345678, 4'b1111);
        add_req(1, 0, 9, '0, '0);
        for (int i = 0; i < plan.size() + LAT + 2; i++) begin
            @(posedge clk); #1;
            if (i < plan.size() && plan[i].en) issue(plan[i]); else idle();
            @(negedge clk);
            n_chk++;
            if (ack) begin
                if (sb.size() == 0) begin n_fail++; $display("FAIL inflight_spurious_ack at cyc %0d, required none", cyc); end
                else begin
                    e = sb.pop_front();
                    if (cyc != e.due) begin n_fail++; $display("FAIL inflight_ack_cycle got %0d required %0d", cyc, e.due); end
                    if (e.rd) last_rd = e.data;
                    n_chk++;
                    if (data_out !== last_rd) begin n_fail++; $display("FAIL inflight_data got %h required %h", data_out, last_rd); end
                end
            end else if (data_out !== last_rd) begin n_fail++; $display("FAIL inflight_hold got %h required %h", data_out, last_rd); end
        end

        // Read accepted, then reset lands on the following cycle.
        @(posedge clk); #1;
        mem_en = 1'b1; mem_write = 1'b0; addr = AW'(9);
        @(posedge clk); #1;
        idle();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_chk += 2;
            if (ack !== 1'b0) begin n_fail++; $display("FAIL inflight_ack got %b required 0", ack); end
            if (data_out !== '0) begin n_fail++; $display("FAIL inflight_data_rst got %h required 0", data_out); end
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
        repeat (5) begin
            @(negedge clk);
            n_chk += 3;
            if (ready !== 1'b0) begin n_fail++; $display("FAIL inflight_ready got %b required 0", ready); end
            if (ack !== 1'b0) begin n_fail++; $display("FAIL inflight_late_ack got %b required 0", ack); end
            if (data_out !== '0) begin n_fail++; $display("FAIL inflight_data_after got %h required 0", data_out); end
        end

        // Reset in the middle of the sweep must restart it from word 0.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ready === 1'b1) break;
            cnt++;
        end
        n_chk++;
        if (cnt != DEPTH) begin n_fail++; $display("FAIL restart_clear_len got %0d cycles, required %0d", cnt, DEPTH); end

        plan.delete();
        add_req(1, 0, 9, '0, '0);
        for (int i = 0; i < plan.size() + LAT + 2; i++) begin
            @(posedge clk); #1;
            if (i < plan.size() && plan[i].en) issue(plan[i]); else idle();
            @(negedge clk);
            n_chk++;
            if (ack) begin
                if (sb.size() == 0) begin n_fail++; $display("FAIL restart_spurious_ack at cyc %0d, required none", cyc); end
                else begin
                    e = sb.pop_front();
                    if (cyc != e.due) begin n_fail++; $display("FAIL restart_ack_cycle got %0d required %0d", cyc, e.due); end
                    if (e.rd) last_rd = e.data;
                    n_chk++;
                    if (data_out !== last_rd) begin n_fail++; $display("FAIL restart_data got %h required %h", data_out, last_rd); end
                end
            end else if (data_out !== last_rd) begin n_fail++; $display("FAIL restart_hold got %h required %h", data_out, last_rd); end
        end
        n_chk++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL restart_missing_ack got %0d pending, required 0", sb.size()); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        model_clear();
        test_reset();
        test_strobe();
        test_back_to_back();
        test_clear_ignore();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
